// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral slice.
// Contents: channel count, counter width, default prescale, the full-duty
// code, and the waveform-level helper used by the timebase.
package pwm_pkg;

  localparam int unsigned PWM_CHANNELS         = 16;
  localparam int unsigned PWM_CNT_W            = 8;
  localparam int unsigned PWM_PRESCALE_DEFAULT = 13;
  localparam logic [PWM_CNT_W-1:0] PWM_DUTY_FULL = 8'hFF;

  typedef logic [PWM_CNT_W-1:0]    pwm_cnt_t;
  typedef logic [PWM_CHANNELS-1:0] pwm_mask_t;

  // Left-aligned waveform level. Full-scale duty is forced high so the
  // waveform has no one-step dip at the end of the period.
  function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == PWM_DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_if.sv
// Register-block to PWM-peripheral link.
// Fields: the four enable bytes and the duty byte written over SPI
// (driven by the register block), plus the pin drive and the period
// marker returned by the peripheral. The peripheral exposes these as flat
// ports; this bundle is wired to them field by field.
//   master : register-block side (drives configuration, observes outputs)
//   slave  : peripheral side (observes configuration, drives outputs)
interface pwm_if;
  import pwm_pkg::*;

  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  pwm_cnt_t   pwm_duty_cycle;
  pwm_mask_t  out;
  logic       period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out, period_start
  );

endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, 8-bit period counter and duty shadow.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   duty_in   : requested duty (sampled only at the period wrap)
//   pwm_high  : current waveform level (combinational from flops)
//   wrap      : true in the last clk cycle of each PWM period
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = PWM_PRESCALE_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  input  pwm_cnt_t duty_in,
  output logic     pwm_high,
  output logic     wrap
);

  localparam pwm_cnt_t PRE_LAST = pwm_cnt_t'(PRESCALE - 1);

  pwm_cnt_t pre_cnt;
  pwm_cnt_t pwm_cnt;
  pwm_cnt_t duty_q;
  logic     step;

  always_comb begin
    step     = (pre_cnt == PRE_LAST);
    wrap     = step && (pwm_cnt == '1);
    pwm_high = pwm_level(pwm_cnt, duty_q);
  end

  // duty_q only moves on the wrap edge, so a period never sees two duties.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pre_cnt <= step ? '0 : pre_cnt + pwm_cnt_t'(1);
      if (step) pwm_cnt <= pwm_cnt + pwm_cnt_t'(1);
      if (wrap) duty_q  <= duty_in;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// PWM peripheral: drives 16 chip pins from the SPI configuration bytes.
// Each pin is forced low, forced high, or follows the shared PWM waveform.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   en_reg_out_7_0/15_8               : per-pin output enable
//   en_reg_pwm_7_0/15_8               : per-pin PWM mode select
//   pwm_duty_cycle                    : duty request, applied at period start
//   out                               : registered pin drive, bit i = pin i
//   period_start                      : one-cycle pulse on each period's first cycle
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = PWM_PRESCALE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  pwm_mask_t en_out;
  pwm_mask_t en_pwm;
  pwm_mask_t out_d;
  logic      pwm_high;
  logic      wrap;

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .duty_in  (pwm_duty_cycle),
    .pwm_high (pwm_high),
    .wrap     (wrap)
  );

  always_comb begin
    en_out = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    out_d  = en_out & (~en_pwm | {PWM_CHANNELS{pwm_high}});
  end

  // Every pin comes straight from a flop so the drive cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_d;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral (default PRESCALE = 13, period 3328).
// Stimulus pushes cycle-stamped pin expectations and per-period expectations;
// a monitor samples on the falling edge and checks them as they come due.
module tb_pwm_peripheral;

  localparam int unsigned P = 3328;

  typedef struct {
    int unsigned t;
    logic [15:0] mask;
    logic [15:0] exp_out;
    logic        exp_ps;
    string       name;
  } samp_t;

  typedef struct {
    int unsigned high0;
    int unsigned high1;
    int unsigned len;
    string       name;
  } per_t;

  logic        clk;
  logic        rst;
  int unsigned tick;
  int unsigned checks;
  int unsigned errors;
  samp_t       sq[$];
  per_t        pq[$];

  pwm_if bus ();

  pwm_peripheral #(.PRESCALE(13)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (bus.en_reg_out_7_0),
    .en_reg_out_15_8 (bus.en_reg_out_15_8),
    .en_reg_pwm_7_0  (bus.en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (bus.en_reg_pwm_15_8),
    .pwm_duty_cycle  (bus.pwm_duty_cycle),
    .out             (bus.out),
    .period_start    (bus.period_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial tick = 0;
  always @(posedge clk) tick <= tick + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick);
    end
  endtask

  task automatic push(input int unsigned t, input logic [15:0] mask,
                      input logic [15:0] e, input logic ps, input string name);
    samp_t s;
    s.t = t; s.mask = mask; s.exp_out = e; s.exp_ps = ps; s.name = name;
    sq.push_back(s);
  endtask

  task automatic push_per(input int unsigned h0, input int unsigned h1, input string name);
    per_t p;
    p.high0 = h0; p.high1 = h1; p.len = P; p.name = name;
    pq.push_back(p);
  endtask

  // Returns 1 ns after the posedge that brings tick to t.
  task automatic at_tick(input int unsigned t);
    while (tick < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_en(input logic [15:0] o, input logic [15:0] p);
    bus.en_reg_out_7_0  = o[7:0];
    bus.en_reg_out_15_8 = o[15:8];
    bus.en_reg_pwm_7_0  = p[7:0];
    bus.en_reg_pwm_15_8 = p[15:8];
  endtask

  // Monitor: cycle-stamped checks plus per-period high-time measurement.
  initial begin : monitor
    bit          active;
    int unsigned h0, h1, last;
    per_t        pe;
    active = 0; h0 = 0; h1 = 0; last = 0;
    forever begin
      @(negedge clk);
      for (int i = int'(sq.size()) - 1; i >= 0; i--) begin
        if (sq[i].t == tick) begin
          chk({sq[i].name, "_out"}, 32'(bus.out & sq[i].mask), 32'(sq[i].exp_out));
          chk({sq[i].name, "_ps"}, 32'(bus.period_start), 32'(sq[i].exp_ps));
          sq.delete(i);
        end
      end
      if (rst) begin
        active = 0; h0 = 0; h1 = 0;
      end else begin
        if (active) begin
          h0 += 32'(bus.out[0]);
          h1 += 32'(bus.out[1]);
        end
        if (bus.period_start) begin
          if (active) begin
            if (pq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_period: got period at tick %0d expected none", tick);
            end else begin
              pe = pq.pop_front();
              chk({pe.name, "_len"}, tick - last, pe.len);
              chk({pe.name, "_high0"}, h0, pe.high0);
              chk({pe.name, "_high1"}, h1, pe.high1);
            end
          end
          active = 1; last = tick; h0 = 0; h1 = 0;
        end
      end
    end
  end

  initial begin : stim
    int unsigned base, base2;
    checks = 0; errors = 0;
    rst = 1'b1;
    set_en(16'hFFFF, 16'hFFFF);
    bus.pwm_duty_cycle = 8'hFF;

    for (int unsigned t = 1; t <= 5; t++) push(t, 16'hFFFF, 16'h0000, 1'b0, "reset");

    // Period expectations in order: (out[0] high, out[1] high).
    push_per(1664, 0,   "p1_duty80");
    push_per(3328, 0,   "p2_dutyFF");
    push_per(3328, 0,   "p3_dutyFF");
    push_per(3328, 0,   "p4_dutyFF");
    push_per(0,    0,   "p5_duty00");
    push_per(832,  0,   "p6_duty40");
    push_per(2496, 0,   "p7_dutyC0");
    push_per(3328, 416, "p8_mixed");
    push_per(3328, 416, "post_reset_mixed");

    at_tick(5);
    rst = 1'b0;
    base = 5;
    set_en(16'h00FF, 16'h0000);
    push(6,  16'hFFFF, 16'h00FF, 1'b0, "static_on");
    push(20, 16'hFFFF, 16'h00FF, 1'b0, "static_hold");
    push(30, 16'hFFFF, 16'h00FF, 1'b0, "static_last");

    at_tick(30);
    set_en(16'h0000, 16'h0000);
    push(31, 16'hFFFF, 16'h0000, 1'b0, "static_off");

    at_tick(40);
    bus.pwm_duty_cycle = 8'h80;
    set_en(16'h0001, 16'h0001);
    push(41,              16'hFFFF, 16'h0000, 1'b0, "first_period_duty0");
    push(base + P - 1,    16'hFFFF, 16'h0000, 1'b0, "before_first_ps");
    push(base + P,        16'hFFFF, 16'h0000, 1'b1, "first_ps");
    push(base + P + 1,    16'hFFFF, 16'h0001, 1'b0, "half_rise");
    push(base + P + 1664, 16'hFFFF, 16'h0001, 1'b0, "half_last_high");
    push(base + P + 1665, 16'hFFFF, 16'h0000, 1'b0, "half_fall");

    at_tick(base + 4000);
    bus.pwm_duty_cycle = 8'hFF;
    push(base + 2*P,     16'hFFFF, 16'h0000, 1'b1, "p2_start");
    push(base + 2*P + 1, 16'hFFFF, 16'h0001, 1'b0, "full_rise");
    push(base + 3*P,     16'hFFFF, 16'h0001, 1'b1, "full_no_dip");

    // Duty write lands on the wrap cycle itself and must still be captured.
    at_tick(base + 5*P - 1);
    bus.pwm_duty_cycle = 8'h00;
    push(base + 5*P,     16'hFFFF, 16'h0001, 1'b1, "wrap_write_old");
    push(base + 5*P + 1, 16'hFFFF, 16'h0000, 1'b0, "wrap_write_new");

    at_tick(base + 17000);
    bus.pwm_duty_cycle = 8'h40;

    at_tick(base + 6*P + 500);
    bus.pwm_duty_cycle = 8'hC0;
    push(base + 6*P + 832, 16'hFFFF, 16'h0001, 1'b0, "mid_change_hold_hi");
    push(base + 6*P + 833, 16'hFFFF, 16'h0000, 1'b0, "mid_change_hold_lo");

    at_tick(base + 7*P + 100);
    bus.pwm_duty_cycle = 8'h20;
    push(base + 7*P + 2496, 16'hFFFF, 16'h0001, 1'b0, "dutyC0_hi");
    push(base + 7*P + 2497, 16'hFFFF, 16'h0000, 1'b0, "dutyC0_lo");

    at_tick(base + 8*P);
    set_en(16'hFFFF, 16'hAAAA);
    push(base + 8*P,       16'hFFFF, 16'h0000, 1'b1, "p8_start");
    push(base + 8*P + 1,   16'hFFFF, 16'hFFFF, 1'b0, "mixed_rise");
    push(base + 8*P + 416, 16'hFFFF, 16'hFFFF, 1'b0, "mixed_last_high");
    push(base + 8*P + 417, 16'hFFFF, 16'h5555, 1'b0, "mixed_fall");

    at_tick(base + 9*P + 999);
    push(base + 9*P + 999,  16'hFFFF, 16'h5555, 1'b0, "pre_reset");
    push(base + 9*P + 1000, 16'hFFFF, 16'h0000, 1'b0, "mid_reset");
    rst = 1'b1;

    at_tick(base + 9*P + 1000);
    rst = 1'b0;
    base2 = base + 9*P + 1000;
    push(base2 + 1,         16'hFFFF, 16'h5555, 1'b0, "restart_duty0");
    push(base2 + 2000,      16'hFFFF, 16'h5555, 1'b0, "restart_hold");
    push(base2 + P - 1,     16'hFFFF, 16'h5555, 1'b0, "restart_before_ps");
    push(base2 + P,         16'hFFFF, 16'h5555, 1'b1, "restart_ps");
    push(base2 + P + 1,     16'hFFFF, 16'hFFFF, 1'b0, "restart_rise");
    push(base2 + P + 417,   16'hFFFF, 16'h5555, 1'b0, "restart_fall");

    at_tick(base2 + 2*P + 4);
    foreach (sq[i]) begin
      checks++; errors++;
      $display("FAIL %s: got no sample expected check at tick %0d", sq[i].name, sq[i].t);
    end
    foreach (pq[i]) begin
      checks++; errors++;
      $display("FAIL %s: got no period end expected period of %0d", pq[i].name, pq[i].len);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Downstream consumer of the SPI register block: takes the five configuration bytes written over SPI and drives the 16 chip output pins. Each pin is forced low, forced high, or driven by a shared PWM waveform. The waveform comes from an 8-bit counter behind a clock prescaler, giving about 3 kHz at 10 MHz. The duty cycle is double-buffered and updates only at period boundaries, so output pulses never glitch.

## Interface
Parameters:
- `PRESCALE`, 13: clk cycles per PWM counter step; legal 1..255.

Ports:
- `clk`  in  1: system clock (10 MHz).
- `rst`  in  1: reset; one clock; reset is synchronous and active-high.
- `en_reg_out_7_0`  in  8: output enable, pins 7..0.
- `en_reg_out_15_8`  in  8: output enable, pins 15..8.
- `en_reg_pwm_7_0`  in  8: PWM mode select, pins 7..0.
- `en_reg_pwm_15_8`  in  8: PWM mode select, pins 15..8.
- `pwm_duty_cycle`  in  8: requested duty; high time = duty/256 of period, 0xFF = 100 %.
- `out`  out  16: pin drive; bit i ↔ pin i.
- `period_start`  out  1: one-cycle pulse on the first cycle of each PWM period.

## Operation
- `en_out = {en_reg_out_15_8, en_reg_out_7_0}` and `en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}`.
- Prescaler `pre_cnt` counts 0..PRESCALE-1 and wraps. `step = (pre_cnt == PRESCALE-1)`.
- PWM counter `pwm_cnt` is 8 bits. It increments on `step` and wraps 255→0 (natural modulo-256).
- Period wrap condition `wrap = step & (pwm_cnt == 255)`.
- Duty shadow `duty_q` loads `pwm_duty_cycle` on the same edge where `wrap` is true, and holds otherwise.
- `pwm_high = (duty_q == 8'hFF) | (pwm_cnt < duty_q)`. Duty 0x00 gives a constantly low waveform. Duty 0xFF gives a constantly high waveform with no 1/256 dip.
- Per pin, registered: `out[i] <= en_out[i] & (~en_pwm[i] | pwm_high)`.
  - `en_out=0`: pin low regardless of `en_pwm`.
  - `en_out=1, en_pwm=0`: pin static high.
  - `en_out=1, en_pwm=1`: pin follows the PWM waveform.
- `period_start <= wrap` (registered). It is asserted in the cycle where `pre_cnt==0` and `pwm_cnt==0`.
- Enable inputs are not shadowed and take effect immediately, subject to the output register latency.
- Inputs are already synchronous to `clk` (SPI block output). No synchronizers are in this block.
- No FSM. All state is counters plus shadow/output registers.

## Timing
- Reset (`rst` high at a clk edge): `pre_cnt=0`, `pwm_cnt=0`, `duty_q=0`, `out=16'h0000`, `period_start=0`. This applies on the edge itself. `rst` takes priority over every other update.
- Reset mid-period: the current period is aborted and the counters restart from 0. The first period after reset always uses `duty_q=0`, so PWM pins stay low for it.
- First `period_start` after reset release: asserted PRESCALE·256 cycles after the first non-reset edge (cycle 3328 with the default).
- Period length: PRESCALE·256 clk cycles, exactly.
- Enable change → `out` update: 1 cycle.
- `pwm_duty_cycle` change → takes effect at the next period start, never mid-period.
- Duty write in the same cycle as `wrap`: the new value is captured and applies to the period beginning next cycle.
- High time per period: `duty_q`·PRESCALE cycles, or full period when `duty_q=0xFF`. The high phase starts at period start (left-aligned).
- `out` is glitch-free: every bit comes straight from a flop.

## Structure
- Shared package `pwm_pkg`:
  - `PWM_CHANNELS=16`
  - `PWM_CNT_W=8`
  - `PWM_PRESCALE_DEFAULT=13`
  - `PWM_DUTY_FULL=8'hFF`
- Sub-module `pwm_timebase` contains the prescaler, `pwm_cnt`, `wrap`, and the `duty_q` shadow. It outputs `pwm_high` and `wrap`.
- The top module holds the 16-wide output mask logic, the `out` register, and the `period_start` register.

## Test plan
- Reset: hold `rst` for 5 cycles with enables 0xFFFF → `out=0x0000` and `period_start=0` throughout. After release, the first `period_start` pulse appears at cycle 3328 and repeats every 3328 cycles.
- Static drive: `en_out=0x00FF`, `en_pwm=0x0000` → `out=0x00FF` 1 cycle later and steady. Then `en_out=0x0000` → `out=0x0000` after 1 cycle.
- 50 % PWM: duty 0x80, `en_out=0x0001`, `en_pwm=0x0001`, waited past one period → `out[0]` is high for 1664 cycles and low for 1664 cycles, rising 1 cycle after `period_start`'s cycle. `out[15:1]` stays 0.
- Extremes: duty 0xFF → `out[0]` constantly 1 across 3 periods. Duty 0x00 → `out[0]` constantly 0.
- Mid-period duty change: duty 0x40 is running, and 0xC0 is written at cycle 500 of a period → that period has 832 high cycles, and the next period has 2496.
- Mixed modes with mid-period reset: `en_out=0xFFFF`, `en_pwm=0xAAAA`, duty 0x20 → even pins static high, odd pins 416-cycle pulses. Asserting `rst` at cycle 1000 of a period → `out=0x0000` on that edge, and the counters restart.
